led_string_rx: RTL and testbench

Serial receiver for the single-wire LED string protocol that `string_driver` transmits. It oversamples `sdi`, classifies each high pulse as a 0 or 1 bit, assembles 24-bit pixels MSB-first and flags end of frame on a long low (latch) period. It sits on `clk_20` and is used for loopback self-test of `led_sdi` and for monitoring the daisy-chain output of a string.

---
 rtl/led_proto_pkg.sv | 13 +
 rtl/sdi_sync.sv | 25 ++
 rtl/led_string_rx.sv | 128 ++++++++++++
 tb/tb_led_string_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_proto_pkg.sv
// led_proto_pkg: timing defaults, pixel width and receiver states shared by both ends of the LED string link
package led_proto_pkg;
  localparam int T_CLK_NS      = 50;
  localparam int T_HIGH_MIN_NS = 150;
  localparam int T_THRESH_NS   = 600;
  localparam int T_HIGH_MAX_NS = 1200;
  localparam int T_RESET_NS    = 50000;
  localparam int PIXEL_BITS    = 24;
  typedef enum logic [1:0] {SYNC, LOW, HIGH} rx_state_e;
  function automatic int ns_to_cycles(input int t_ns, input int clk_ns);
    return t_ns / clk_ns;
  endfunction
endpackage

// File: rtl/sdi_sync.sv
// sdi_sync: two-flop synchronizer for the serial line with registered copy for rise/fall detection
module sdi_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_sdi,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta, r_s, r_s_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_s    <= 1'b0;
      r_s_d  <= 1'b0;
    end else begin
      r_meta <= i_sdi;
      r_s    <= r_meta;
      r_s_d  <= r_s;
    end
  end
  assign o_s    = r_s;
  assign o_rise = r_s & ~r_s_d;
  assign o_fall = ~r_s & r_s_d;
endmodule

// File: rtl/led_string_rx.sv
// led_string_rx: oversampling receiver decoding LED string pulses into 24-bit pixels with latch detection
module led_string_rx
  import led_proto_pkg::*;
#(
  parameter int CLK_PERIOD_NS = T_CLK_NS,
  parameter int T_HIGH_MIN_NS = led_proto_pkg::T_HIGH_MIN_NS,
  parameter int T_THRESH_NS   = led_proto_pkg::T_THRESH_NS,
  parameter int T_HIGH_MAX_NS = led_proto_pkg::T_HIGH_MAX_NS,
  parameter int T_RESET_NS    = led_proto_pkg::T_RESET_NS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sdi,
  output logic [PIXEL_BITS-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic                  frame_end,
  output logic [15:0]           pixel_count,
  output logic                  bit_err
);
  localparam int MIN = ns_to_cycles(T_HIGH_MIN_NS, CLK_PERIOD_NS);
  localparam int THR = ns_to_cycles(T_THRESH_NS, CLK_PERIOD_NS);
  localparam int MAX = ns_to_cycles(T_HIGH_MAX_NS, CLK_PERIOD_NS);
  localparam int RST = ns_to_cycles(T_RESET_NS, CLK_PERIOD_NS);
  localparam int CW  = $clog2(RST + 1);
  localparam int BW  = $clog2(PIXEL_BITS);
  localparam logic [CW-1:0] C_MIN  = CW'(MIN);
  localparam logic [CW-1:0] C_THR  = CW'(THR);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX);
  localparam logic [CW-1:0] C_RST  = CW'(RST);
  localparam logic [BW-1:0] C_LAST = BW'(PIXEL_BITS - 1);
  logic w_s, w_rise, w_fall;
  rx_state_e r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [BW-1:0] r_bit_cnt, w_bit_cnt;
  logic [PIXEL_BITS-1:0] r_shift, w_shift, r_pixel_data;
  logic [15:0] r_pixel_count;
  logic r_fe_done, w_fe_done, w_take, w_fe, w_err, w_pix;
  logic r_pixel_valid, r_frame_end, r_bit_err;
  sdi_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .i_sdi (sdi),
    .o_s   (w_s),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );
  assign w_cnt_inc = (r_cnt == C_RST) ? r_cnt : r_cnt + 1'b1;
  assign w_pix     = w_take && (r_bit_cnt == C_LAST);
  // counter holds the number of cycles already spent at the current level, so edges load 1
  always_comb begin
    w_state   = r_state;
    w_cnt     = w_cnt_inc;
    w_bit_cnt = r_bit_cnt;
    w_shift   = r_shift;
    w_fe_done = r_fe_done;
    w_take    = 1'b0;
    w_fe      = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      SYNC: begin
        w_cnt = w_s ? '0 : w_cnt_inc;
        if (!w_s && w_cnt_inc == C_RST) begin
          w_state   = LOW;
          w_fe_done = 1'b1;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state = HIGH;
          w_cnt   = CW'(1);
        end else if (w_cnt_inc == C_RST && !r_fe_done) begin
          w_fe      = 1'b1;
          w_fe_done = 1'b1;
          w_err     = (r_bit_cnt != '0);
          w_bit_cnt = '0;
        end
      end
      HIGH: begin
        if (r_cnt >= C_MAX || (w_fall && r_cnt < C_MIN)) begin
          w_err     = 1'b1;
          w_state   = SYNC;
          w_cnt     = CW'(!w_s);
          w_bit_cnt = '0;
        end else if (w_fall) begin
          w_take    = 1'b1;
          w_state   = LOW;
          w_cnt     = CW'(1);
          w_fe_done = 1'b0;
          w_shift   = {r_shift[PIXEL_BITS-2:0], r_cnt >= C_THR};
          w_bit_cnt = (r_bit_cnt == C_LAST) ? '0 : r_bit_cnt + 1'b1;
        end
      end
      default: w_state = SYNC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= SYNC;
      r_cnt         <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_fe_done     <= 1'b0;
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_frame_end   <= 1'b0;
      r_bit_err     <= 1'b0;
      r_pixel_count <= '0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_bit_cnt     <= w_bit_cnt;
      r_shift       <= w_shift;
      r_fe_done     <= w_fe_done;
      r_pixel_valid <= w_pix;
      r_frame_end   <= w_fe;
      r_bit_err     <= w_err;
      if (w_pix) r_pixel_data <= w_shift;
      // the total stays visible for the frame_end cycle, even when a partial pixel errors with it
      r_pixel_count <= (r_frame_end || (w_err && !w_fe)) ? '0 :
                       (w_pix && r_pixel_count != '1) ? r_pixel_count + 1'b1 : r_pixel_count;
    end
  end
  assign pixel_data  = r_pixel_data;
  assign pixel_valid = r_pixel_valid;
  assign frame_end   = r_frame_end;
  assign bit_err     = r_bit_err;
  assign pixel_count = r_pixel_count;
endmodule

// File: tb/tb_led_string_rx.sv
// tb_led_string_rx: randomized pulse-train stimulus checked against a pulse-level protocol model
module tb_led_string_rx;
  localparam int MIN = 150 / 50;
  localparam int THR = 600 / 50;
  localparam int MAX = 1200 / 50;
  localparam int RST = 50000 / 50;
  logic clk = 1'b0, reset = 1'b1, sdi = 1'b0;
  logic [23:0] pixel_data;
  logic [15:0] pixel_count;
  logic pixel_valid, frame_end, bit_err;
  int errors = 0, checks = 0;
  string act_pix, exp_pix, act_fe, exp_fe, act_err, exp_err, act_bad;
  bit m_sync, m_armed;
  int m_nbits, m_pc, m_hrun, m_lrun;
  logic [23:0] m_sh;
  logic pv_q = 1'b0, fe_q = 1'b0, be_q = 1'b0;
  led_string_rx dut (
    .clk        (clk),
    .reset      (reset),
    .sdi        (sdi),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .frame_end  (frame_end),
    .pixel_count(pixel_count),
    .bit_err    (bit_err)
  );
  always #5 clk = ~clk;
  // event log: pixels, frame ends as "<count at strobe>><count next cycle>", errors tagged E when coincident with frame_end
  always @(negedge clk) begin
    if (reset) begin
      pv_q = 1'b0; fe_q = 1'b0; be_q = 1'b0;
    end else begin
      if (pixel_valid) act_pix = $sformatf("%s%06h ", act_pix, pixel_data);
      if (fe_q) act_fe = $sformatf("%s>%0d ", act_fe, pixel_count);
      if (frame_end) act_fe = $sformatf("%s%0d", act_fe, pixel_count);
      if (bit_err) act_err = $sformatf("%s%s", act_err, frame_end ? "E" : "e");
      if ((pixel_valid && pv_q) || (frame_end && fe_q) || (bit_err && be_q)) act_bad = $sformatf("%sW", act_bad);
      pv_q = pixel_valid; fe_q = frame_end; be_q = bit_err;
    end
  end
  task automatic m_rst();
    m_sync = 1; m_armed = 0; m_nbits = 0; m_pc = 0; m_hrun = 0; m_lrun = 0; m_sh = '0;
  endtask
  task automatic clear_log();
    act_pix = ""; exp_pix = ""; act_fe = ""; exp_fe = ""; act_err = ""; exp_err = ""; act_bad = "";
  endtask
  task automatic m_high(input int w);
    if (m_sync) return;
    if (w < MIN || w >= MAX) begin
      exp_err = $sformatf("%se", exp_err);
      m_sync = 1; m_nbits = 0; m_pc = 0;
    end else begin
      m_sh = {m_sh[22:0], w >= THR};
      m_armed = 1;
      m_nbits++;
      if (m_nbits == 24) begin
        exp_pix = $sformatf("%s%06h ", exp_pix, m_sh);
        m_nbits = 0;
        if (m_pc < 65535) m_pc++;
      end
    end
  endtask
  task automatic m_low();
    if (m_sync) begin
      if (m_lrun >= RST) begin m_sync = 0; m_armed = 0; end
    end else if (m_armed && m_lrun >= RST) begin
      exp_fe = $sformatf("%s%0d>0 ", exp_fe, m_pc);
      if (m_nbits != 0) exp_err = $sformatf("%sE", exp_err);
      m_nbits = 0; m_pc = 0; m_armed = 0;
    end
  endtask
  task automatic seg(input bit lvl, input int len);
    if (lvl) begin
      m_hrun += len; m_lrun = 0;
    end else begin
      if (m_hrun > 0) m_high(m_hrun);
      m_hrun = 0; m_lrun += len;
      m_low();
    end
    sdi = lvl;
    repeat (len) @(posedge clk);
    #1;
  endtask
  task automatic bit_tx(input int hw, input int lw);
    seg(1, hw);
    seg(0, lw);
  endtask
  // mode 0: nominal 16/9 and 8/17 widths, 1: random legal widths, 2: widths at the class edges with 1-cycle gaps
  task automatic px_tx(input logic [23:0] p, input int mode, input int nbits = 24);
    int hw, lw;
    for (int i = 23; i > 23 - nbits; i--) begin
      if (mode == 0) begin
        hw = p[i] ? 16 : 8; lw = p[i] ? 9 : 17;
      end else if (mode == 1) begin
        hw = p[i] ? int'($urandom_range(MAX - 1, THR)) : int'($urandom_range(THR - 1, MIN));
        lw = int'($urandom_range(20, 1));
      end else begin
        hw = p[i] ? (($urandom_range(1, 0) == 1) ? MAX - 1 : THR) : (($urandom_range(1, 0) == 1) ? THR - 1 : MIN);
        lw = 1;
      end
      bit_tx(hw, lw);
    end
  endtask
  task automatic latch();
    seg(0, RST);
    seg(0, 8);
  endtask
  task automatic test_reset();
    reset = 1; sdi = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pixel_data !== 24'h0) begin errors++; $display("FAIL reset pixel_data: got %h want 000000", pixel_data); end
    checks++; if (pixel_count !== 16'h0) begin errors++; $display("FAIL reset pixel_count: got %0d want 0", pixel_count); end
    checks++; if ({pixel_valid, frame_end, bit_err} !== 3'b000) begin errors++; $display("FAIL reset strobes: got %b want 000", {pixel_valid, frame_end, bit_err}); end
    reset = 0;
    m_rst();
    clear_log();
    seg(0, RST);
  endtask
  task automatic test_single();
    clear_log();
    px_tx(24'hA5C3F0, 0);
    latch();
    checks++; if (act_pix != "a5c3f0 ") begin errors++; $display("FAIL single pix: got '%s' want 'a5c3f0 '", act_pix); end
    checks++; if (act_fe != exp_fe) begin errors++; $display("FAIL single fe: got '%s' want '%s'", act_fe, exp_fe); end
    checks++; if (act_err != exp_err) begin errors++; $display("FAIL single err: got '%s' want '%s'", act_err, exp_err); end
  endtask
  task automatic test_multi();
    clear_log();
    px_tx(24'hFFFFFF, 0);
    px_tx(24'h000000, 0);
    px_tx(24'h123456, 0);
    latch();
    checks++; if (act_pix != exp_pix) begin errors++; $display("FAIL multi pix: got '%s' want '%s'", act_pix, exp_pix); end
    checks++; if (act_fe != exp_fe) begin errors++; $display("FAIL multi fe: got '%s' want '%s'", act_fe, exp_fe); end
    checks++; if (act_err != exp_err) begin errors++; $display("FAIL multi err: got '%s' want '%s'", act_err, exp_err); end
  endtask
  task automatic test_threshold();
    clear_log();
    for (int i = 0; i < 24; i++) bit_tx((i % 2 == 0) ? THR - 1 : THR, 9);
    px_tx($urandom, 2);
    latch();
    checks++; if (act_pix != exp_pix) begin errors++; $display("FAIL threshold pix: got '%s' want '%s'", act_pix, exp_pix); end
    checks++; if (act_fe != exp_fe) begin errors++; $display("FAIL threshold fe: got '%s' want '%s'", act_fe, exp_fe); end
    checks++; if (act_err != exp_err) begin errors++; $display("FAIL threshold err: got '%s' want '%s'", act_err, exp_err); end
  endtask
  task automatic test_glitch();
    clear_log();
    px_tx($urandom, 1, 5);
    bit_tx(MIN - 1, 5);
    px_tx($urandom, 1);
    px_tx($urandom, 1, 6);
    seg(0, RST);
    px_tx($urandom, 1);
    latch();
    checks++; if (act_pix != exp_pix) begin errors++; $display("FAIL glitch pix: got '%s' want '%s'", act_pix, exp_pix); end
    checks++; if (act_fe != exp_fe) begin errors++; $display("FAIL glitch fe: got '%s' want '%s'", act_fe, exp_fe); end
    checks++; if (act_err != exp_err) begin errors++; $display("FAIL glitch err: got '%s' want '%s'", act_err, exp_err); end
  endtask
  task automatic test_partial();
    clear_log();
    px_tx($urandom, 1, 10);
    latch();
    seg(1, 30);
    latch();
    px_tx($urandom, 1);
    latch();
    checks++; if (act_pix != exp_pix) begin errors++; $display("FAIL partial pix: got '%s' want '%s'", act_pix, exp_pix); end
    checks++; if (act_fe != exp_fe) begin errors++; $display("FAIL partial fe: got '%s' want '%s'", act_fe, exp_fe); end
    checks++; if (act_err != exp_err) begin errors++; $display("FAIL partial err: got '%s' want '%s'", act_err, exp_err); end
  endtask
  task automatic test_midstream();
    reset = 1; sdi = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    m_rst();
    clear_log();
    px_tx($urandom, 1);
    px_tx($urandom, 1, 7);
    seg(0, RST);
    px_tx($urandom, 1);
    latch();
    checks++; if (act_pix != exp_pix) begin errors++; $display("FAIL midstream pix: got '%s' want '%s'", act_pix, exp_pix); end
    checks++; if (act_fe != exp_fe) begin errors++; $display("FAIL midstream fe: got '%s' want '%s'", act_fe, exp_fe); end
    checks++; if (act_err != exp_err) begin errors++; $display("FAIL midstream err: got '%s' want '%s'", act_err, exp_err); end
  endtask
  task automatic test_reset_mid();
    clear_log();
    px_tx($urandom, 1);
    px_tx($urandom, 1, 12);
    reset = 1; sdi = 0;
    @(posedge clk);
    #1;
    checks++; if (pixel_data !== 24'h0) begin errors++; $display("FAIL reset_mid pixel_data: got %h want 000000", pixel_data); end
    checks++; if (pixel_count !== 16'h0) begin errors++; $display("FAIL reset_mid pixel_count: got %0d want 0", pixel_count); end
    checks++; if ({pixel_valid, frame_end, bit_err} !== 3'b000) begin errors++; $display("FAIL reset_mid strobes: got %b want 000", {pixel_valid, frame_end, bit_err}); end
    reset = 0;
    m_rst();
    clear_log();
    seg(0, RST);
    px_tx($urandom, 1);
    px_tx($urandom, 1);
    latch();
    checks++; if (act_pix != exp_pix) begin errors++; $display("FAIL reset_mid pix: got '%s' want '%s'", act_pix, exp_pix); end
    checks++; if (act_fe != exp_fe) begin errors++; $display("FAIL reset_mid fe: got '%s' want '%s'", act_fe, exp_fe); end
    checks++; if (act_err != exp_err) begin errors++; $display("FAIL reset_mid err: got '%s' want '%s'", act_err, exp_err); end
  endtask
  task automatic test_random();
    clear_log();
    for (int f = 0; f < 4; f++) begin
      for (int p = int'($urandom_range(3, 1)); p > 0; p--) px_tx($urandom, 1);
      if ($urandom_range(2, 0) == 0) px_tx($urandom, 1, int'($urandom_range(23, 1)));
      if ($urandom_range(3, 0) == 0) begin
        px_tx($urandom, 1, 3);
        bit_tx(int'($urandom_range(MIN - 1, 1)), 5);
        seg(0, RST);
      end
      latch();
    end
    checks++; if (act_pix != exp_pix) begin errors++; $display("FAIL random pix: got '%s' want '%s'", act_pix, exp_pix); end
    checks++; if (act_fe != exp_fe) begin errors++; $display("FAIL random fe: got '%s' want '%s'", act_fe, exp_fe); end
    checks++; if (act_err != exp_err) begin errors++; $display("FAIL random err: got '%s' want '%s'", act_err, exp_err); end
    checks++; if (act_bad != "") begin errors++; $display("FAIL random strobe_width: got '%s' want ''", act_bad); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_multi();
    test_threshold();
    test_glitch();
    test_partial();
    test_midstream();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
